// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per accepted
// memory handshake and loads it, with its PC+4, into the IF/ID register.
// Taken branches and jumps redirect the PC and flush IF/ID. A misaligned
// redirect target parks the stage in a sticky FAULT state until reset.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;
  logic        fault_q;

  logic        redirect_d;
  logic [31:0] target_d;
  logic        misaligned_d;
  logic        handshake_d;
  logic [31:0] pc_plus4_d;

  // Request, redirect selection and PC increment. The branch comes from an
  // older instruction than the jump, so its target wins when both fire.
  always_comb begin
    imem_req     = (state_q == ST_FETCH) && !stall;
    handshake_d  = imem_req && imem_ready;
    redirect_d   = branch_taken || jump;
    target_d     = branch_taken ? branch_target : jump_target;
    misaligned_d = (target_d[1:0] != 2'b00);
    pc_plus4_d   = pc_q + 32'd4;  // wraps modulo 2^32 by construction
  end

  // Fetch FSM: redirect (faulting or not) beats stall, stall beats a
  // handshake, and a missed handshake inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc_plus4_q <= 32'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (redirect_d) begin
            // Target is loaded even when misaligned so it can be inspected.
            pc_q    <= target_d;
            valid_q <= 1'b0;
            if (misaligned_d) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end else if (stall) begin
            // Hold PC and all of IF/ID, valid included.
          end else if (handshake_d) begin
            instr_q    <= imem_rdata;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
            pc_q       <= pc_plus4_d;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_FAULT: begin
          // Only reset leaves this state; everything else is ignored.
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= ST_FAULT;
          valid_q <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // Outputs come straight from the registers with no extra logic.
  always_comb begin
    imem_addr      = pc_q;
    pc             = pc_q;
    if_id_instr    = instr_q;
    if_id_pc_plus4 = pc_plus4_q;
    if_id_valid    = valid_q;
    fetch_fault    = fault_q;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, wait states,
// stall, redirect priority, PC wrap, misaligned fault and async reset.
module tb_instruction_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    jump = 1'b0; jump_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    #1;
    check("rst_pc",    pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4",   if_id_pc_plus4, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);
    #12;
    reset = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0 ^ K;
    #1;
    check("seq_addr0", imem_addr, 32'h0);
    check("seq_req0",  {31'd0, imem_req}, 32'd1);

    // Sequential fetch
    step();
    check("seq_addr4",  imem_addr, 32'h4);
    check("seq_pc4_4",  if_id_pc_plus4, 32'h4);
    check("seq_instr0", if_id_instr, 32'h0 ^ K);
    check("seq_valid0", {31'd0, if_id_valid}, 32'd1);
    imem_rdata = 32'h4 ^ K;
    step();
    check("seq_addr8",  imem_addr, 32'h8);
    check("seq_pc4_8",  if_id_pc_plus4, 32'h8);
    check("seq_instr4", if_id_instr, 32'h4 ^ K);
    check("seq_valid1", {31'd0, if_id_valid}, 32'd1);

    // Wait states at pc=8
    imem_ready = 1'b0;
    imem_rdata = 32'h8 ^ K;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_pc",    pc, 32'h8);
      check("wait_valid", {31'd0, if_id_valid}, 32'd0);
      check("wait_instr", if_id_instr, 32'h4 ^ K);
    end
    imem_ready = 1'b1;
    step();
    check("wait_done_pc",    pc, 32'hC);
    check("wait_done_instr", if_id_instr, 32'h8 ^ K);
    check("wait_done_pc4",   if_id_pc_plus4, 32'hC);
    check("wait_done_valid", {31'd0, if_id_valid}, 32'd1);
    imem_rdata = 32'hC ^ K;
    step();
    check("pre_stall_pc", pc, 32'h10);

    // Stall at pc=16
    stall = 1'b1;
    imem_rdata = 32'h10 ^ K;
    #1;
    check("stall_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_pc",    pc, 32'h10);
      check("stall_instr", if_id_instr, 32'hC ^ K);
      check("stall_valid", {31'd0, if_id_valid}, 32'd1);
      check("stall_pc4",   if_id_pc_plus4, 32'h10);
    end
    stall = 1'b0;
    #1;
    check("unstall_req", {31'd0, imem_req}, 32'd1);
    step();
    check("resume_pc",    pc, 32'h14);
    check("resume_instr", if_id_instr, 32'h10 ^ K);

    // Run up to pc=40
    for (int a = 32'h14; a < 32'h28; a += 4) begin
      imem_rdata = a ^ K;
      step();
      check("run_pc", pc, a + 4);
    end

    // Redirect priority: branch beats jump, flush beats stall
    imem_rdata = 32'h28 ^ K;
    stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h100;
    jump = 1'b1;         jump_target   = 32'h200;
    step();
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;
    check("redir_pc",    pc, 32'h100);
    check("redir_valid", {31'd0, if_id_valid}, 32'd0);
    check("redir_instr", if_id_instr, 32'h24 ^ K);
    imem_rdata = 32'h100 ^ K;
    step();
    check("tgt_pc",    pc, 32'h104);
    check("tgt_instr", if_id_instr, 32'h100 ^ K);
    check("tgt_pc4",   if_id_pc_plus4, 32'h104);
    check("tgt_valid", {31'd0, if_id_valid}, 32'd1);

    // Jump to top of memory, then wrap
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    imem_rdata = 32'h104 ^ K;
    step();
    jump = 1'b0;
    check("jmp_pc",    pc, 32'hFFFF_FFFC);
    check("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    imem_rdata = 32'hFFFF_FFFC ^ K;
    step();
    check("wrap_pc",    pc, 32'h0);
    check("wrap_pc4",   if_id_pc_plus4, 32'h0);
    check("wrap_instr", if_id_instr, 32'hFFFF_FFFC ^ K);
    check("wrap_fault", {31'd0, fetch_fault}, 32'd0);

    // Misaligned jump -> sticky fault
    jump = 1'b1; jump_target = 32'h0000_0102;
    step();
    jump = 1'b0;
    check("flt_fault", {31'd0, fetch_fault}, 32'd1);
    check("flt_pc",    pc, 32'h102);
    check("flt_valid", {31'd0, if_id_valid}, 32'd0);
    check("flt_req",   {31'd0, imem_req}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h300;
    for (int i = 0; i < 2; i++) begin
      step();
      check("flt_hold_fault", {31'd0, fetch_fault}, 32'd1);
      check("flt_hold_req",   {31'd0, imem_req}, 32'd0);
      check("flt_hold_pc",    pc, 32'h102);
    end
    branch_taken = 1'b0;

    // Asynchronous reset mid-cycle clears the fault
    #2;
    reset = 1'b1;
    #1;
    check("arst_pc",    pc, 32'h0);
    check("arst_fault", {31'd0, fetch_fault}, 32'd0);
    check("arst_instr", if_id_instr, 32'h0);
    check("arst_valid", {31'd0, if_id_valid}, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("arst_req", {31'd0, imem_req}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the MIPS pipeline. Holds the program counter and fetches one instruction per accepted memory handshake, presenting it with its PC+4 to the IF/ID register. It sits downstream of the next-PC/branch-target adder, which supplies `branch_target`, and upstream of decode. Handles hazard stalls, taken-branch/jump redirects with IF/ID flush, and misaligned-target faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard-unit hold; freezes PC and IF/ID.
- `branch_taken` in 1: resolved branch (Branch && Zero) from EX; one-cycle pulse.
- `branch_target` in 32: PC+4 + (sign-extended offset << 2), from the PC adder.
- `jump` in 1: jump decoded in ID; one-cycle pulse.
- `jump_target` in 32: full jump address.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ready` in 1: memory accepts and returns data this cycle.
- `imem_rdata` in 32: instruction word; valid when `imem_req && imem_ready`.
- `pc` out 32: current fetch PC.
- `if_id_instr` out 32: registered instruction.
- `if_id_pc_plus4` out 32: registered PC+4 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction; 0 means bubble.
- `fetch_fault` out 1: sticky misaligned-target fault.

## Operation
- **Reset values** (asynchronous): `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc_plus4`=0, `if_id_valid`=0, `fetch_fault`=0, state=FETCH.
- **States:** FETCH and FAULT.
- **Handshake:** occurs when `imem_req && imem_ready`.
- **Request:** `imem_req` = (state==FETCH) && !`stall`. It is combinational and does not depend on the redirect inputs.
- **Redirect target:**
  - Redirect = `branch_taken` || `jump`.
  - If both are asserted, `branch_taken` wins because it belongs to the older instruction.
- **FETCH, priority per cycle (highest first):**
  1. Redirect with a target where bits [1:0] != 0: next state is FAULT. `fetch_fault` goes to 1, `if_id_valid` goes to 0, and `pc` loads the target for debug.
  2. Aligned redirect: `pc` loads the target and `if_id_valid` goes to 0. Any handshake in the same cycle is discarded. This applies even while `stall`=1, so a flush overrides a stall.
  3. `stall`=1: `pc` and all `if_id_*` outputs hold their values, including `if_id_valid`.
  4. Handshake: `if_id_instr` loads `imem_rdata`, `if_id_pc_plus4` loads `pc`+4, `if_id_valid` goes to 1, and `pc` advances to `pc`+4.
  5. No handshake: `pc` holds, `if_id_valid` goes to 0 (a bubble is inserted), and the other `if_id_*` outputs hold.
- **FAULT:**
  - `imem_req`=0 and `fetch_fault`=1.
  - `if_id_valid`=0.
  - `pc` holds and all inputs are ignored.
  - Only `reset` exits this state.
- **Arithmetic:** PC+4 is computed modulo 2^32, so 32'hFFFF_FFFC increments to 32'h0000_0000 with no fault.

## Timing
- `imem_addr` and `pc` come straight from the PC register, with no added delay.
- Memory latency is 0 or more wait cycles. A handshake in cycle N makes the instruction visible on `if_id_*` in cycle N+1.
- Throughput with `imem_ready` held at 1 and no stalls: one instruction per cycle.
- Redirect penalty:
  - A redirect in cycle N puts the target on `imem_addr` in cycle N+1.
  - `if_id_valid` is 0 in cycle N+1.
  - The first target instruction reaches IF/ID in cycle N+2 at the earliest.
- Asserting `reset` mid-wait or mid-stall clears state immediately. `imem_req` may rise in the first cycle after reset deasserts.
- Redirect pulses are sampled only at the clock edge. Holding a redirect input for multiple cycles re-redirects every cycle.

## Test plan
- **Sequential fetch:** reset with RESET_PC=0, then hold `imem_ready`=1 with `imem_rdata`=addr^32'hA5A5_0000.
  - `imem_addr` = 0, 4, 8, 12 on successive cycles.
  - `if_id_pc_plus4` = 4, 8, 12 one cycle later.
  - `if_id_valid` stays 1.
- **Wait states:** `imem_ready` low for 3 cycles at `pc`=8.
  - `pc` holds at 8 and `if_id_valid`=0 for 3 cycles.
  - On the 4th cycle the handshake loads the instruction and `pc` becomes 12.
- **Stall:** assert `stall` for 2 cycles with `if_id_instr`=X at `pc`=16.
  - `imem_req`=0, `pc` stays 16, and `if_id_instr`=X with valid held at 1.
  - After release, fetch resumes at 16.
- **Redirect priority:** at `pc`=40, assert `branch_taken` with target 32'h100 together with `jump` with target 32'h200, and `stall`=1, during a handshake.
  - Next cycle: `pc`=32'h100 and `if_id_valid`=0.
  - The instruction fetched at 40 never appears on IF/ID.
- **Wrap and fault:**
  - Jump to 32'hFFFF_FFFC: after the handshake, `pc`=0 and `if_id_pc_plus4`=0.
  - Then jump to 32'h0000_0102: `fetch_fault`=1 and `imem_req`=0 persist until reset, after which `pc`=RESET_PC and `fetch_fault`=0.
